// File: rtl/hlc_pacing_scheduler.sv
// RTLola high-level controller: global timer, stream pacing and a show-ahead event FIFO for the LLC.
// Optional build macro HLC_OVERFLOW_DROP_OLDEST_EN: a full FIFO discards its head instead of the new entry.
module hlc_pacing_scheduler #(
  parameter int DATA_W   = 64,
  parameter int TS_W     = 64,
  parameter int PERIOD_B = 1000,
  parameter int QDEPTH   = 4,
  parameter int PTR_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,         // synchronous, active-low
  input  logic              en_i,
  input  logic [DATA_W-1:0] input_x_i,
  input  logic              new_input_i,
  input  logic              llc_ready_i,
  output logic              q_valid_o,
  output logic [DATA_W-1:0] q_data_o,
  output logic [TS_W-1:0]   q_ts_o,
  output logic              q_pacing_a_o,
  output logic              q_pacing_b_o,
  output logic              q_slide_b_o,
  output logic [TS_W-1:0]   hlc_timer_o,
  output logic              q_push_o,
  output logic              push_valid_o,
  output logic              q_pop_o,
  output logic              pop_valid_o,
  output logic [PTR_W:0]    q_count_o,
  output logic              overflow_o
);

  localparam int CNT_W = (PERIOD_B > 1) ? $clog2(PERIOD_B) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
    logic              pacing_a;
    logic              pacing_b;
    logic              slide_b;
  } entry_t;

  entry_t             mem_q [QDEPTH];
  entry_t             new_entry;
  entry_t             head;

  logic [TS_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               q_push_q, push_valid_q, q_pop_q, pop_valid_q, overflow_q;

  logic               tick, event_w, full, empty, pop, push, drop, lost;

  always_comb begin
    tick    = (per_q == CNT_W'(PERIOD_B - 1));
    event_w = en_i & (new_input_i | tick);
    full    = (count_q == (PTR_W+1)'(QDEPTH));
    empty   = (count_q == '0);
    pop     = en_i & llc_ready_i & ~empty;
    lost    = event_w & full & ~pop;
`ifdef HLC_OVERFLOW_DROP_OLDEST_EN
    // The tail slot equals the head slot when full, so the write overwrites the discarded head.
    push    = event_w;
    drop    = lost;
`else
    push    = event_w & (~full | pop);
    drop    = 1'b0;
`endif

    new_entry.data     = new_input_i ? input_x_i : '0;
    new_entry.ts       = timer_q;
    new_entry.pacing_a = new_input_i;
    new_entry.pacing_b = tick;
    new_entry.slide_b  = tick;

    timer_d  = en_i ? timer_q + 1'b1 : timer_q;
    per_d    = per_q;
    if (en_i) per_d = tick ? '0 : per_q + 1'b1;

    rd_ptr_d = rd_ptr_q + PTR_W'(pop | drop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop | drop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      timer_q      <= '0;
      per_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      q_push_q     <= 1'b0;
      push_valid_q <= 1'b0;
      q_pop_q      <= 1'b0;
      pop_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      per_q        <= per_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      q_push_q     <= event_w;
      push_valid_q <= push;
      q_pop_q      <= en_i & llc_ready_i;
      pop_valid_q  <= pop;
      overflow_q   <= overflow_q | lost;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (rst_i && push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    q_valid_o    = ~empty;
    q_data_o     = empty ? '0 : head.data;
    q_ts_o       = empty ? '0 : head.ts;
    q_pacing_a_o = ~empty & head.pacing_a;
    q_pacing_b_o = ~empty & head.pacing_b;
    q_slide_b_o  = ~empty & head.slide_b;
  end

  assign hlc_timer_o  = timer_q;
  assign q_push_o     = q_push_q;
  assign push_valid_o = push_valid_q;
  assign q_pop_o      = q_pop_q;
  assign pop_valid_o  = pop_valid_q;
  assign q_count_o    = count_q;
  assign overflow_o   = overflow_q;

endmodule
